wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_skid_slot.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: source-select encoding, register address width
// and the default datapath width.
package wb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ALU      = 2'd0,
    DATA_MEM = 2'd1,
    PC       = 2'd2
  } wb_sel_t;

endpackage

// File: rtl/wb_skid_slot.sv
// Single-entry valid/ready holding register. Accepts when empty or draining,
// and is emptied by the drain or clear inputs.
module wb_skid_slot
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  drain,
  output logic                  full,
  output logic [1:0]            out_sel,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_data
);

  logic                  full_r;
  logic [1:0]            sel_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [XLEN-1:0]       data_r;
  logic                  accept_s;

  // A clear wins over acceptance so a flushed request never lands in the slot
  assign in_ready = rst_n & ~clear & (~full_r | drain);
  assign accept_s = in_valid & in_ready;

  // Slot occupancy and payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      sel_r  <= 2'd0;
      rd_r   <= {REG_ADDR_W{1'b0}};
      data_r <= {XLEN{1'b0}};
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (accept_s) begin
      full_r <= 1'b1;
      sel_r  <= in_sel;
      rd_r   <= in_rd;
      data_r <= in_data;
    end else if (drain) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign full     = full_r;
  assign out_sel  = sel_r;
  assign out_rd   = rd_r;
  assign out_data = data_r;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: EX and load requests are buffered in one-entry slots
// and granted one per cycle into a registered register-file write port.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int          XLEN       = XLEN_DEFAULT,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [1:0]            ex_sel,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_alu_data,
  input  logic [XLEN-1:0]       ex_pc_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [1:0]            wb_sel
);

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]            ex_cap_sel_s;
  logic [XLEN-1:0]       ex_cap_data_s;
  logic                  ex_full_s, ld_full_s;
  logic [1:0]            ex_sel_q_s, ld_sel_q_s;
  logic [REG_ADDR_W-1:0] ex_rd_q_s, ld_rd_q_s;
  logic [XLEN-1:0]       ex_data_q_s, ld_data_q_s;
  logic                  grant_ex_s, grant_ld_s, ex_elig_s;
  logic [1:0]            win_sel_s;
  logic [REG_ADDR_W-1:0] win_rd_s;
  logic [XLEN-1:0]       win_data_s;
  logic [SW-1:0]         starve_cnt_r;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_rd_r;
  logic [XLEN-1:0]       rf_wdata_r;
  logic [1:0]            wb_sel_r;

  // EX source mux; anything other than PC (including the illegal codes) is ALU
  always_comb begin
    ex_cap_sel_s  = ALU;
    ex_cap_data_s = ex_alu_data;
    if (ex_sel == PC) begin
      ex_cap_sel_s  = PC;
      ex_cap_data_s = ex_pc_data;
    end else begin
      ex_cap_sel_s  = ALU;
      ex_cap_data_s = ex_alu_data;
    end
  end

  wb_skid_slot #(.XLEN(XLEN)) u_ex_slot (
    .clk(clk), .rst_n(rst_n), .clear(flush),
    .in_valid(ex_valid), .in_ready(ex_ready),
    .in_sel(ex_cap_sel_s), .in_rd(ex_rd), .in_data(ex_cap_data_s),
    .drain(grant_ex_s), .full(ex_full_s),
    .out_sel(ex_sel_q_s), .out_rd(ex_rd_q_s), .out_data(ex_data_q_s)
  );

  wb_skid_slot #(.XLEN(XLEN)) u_ld_slot (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(ld_valid), .in_ready(ld_ready),
    .in_sel(DATA_MEM), .in_rd(ld_rd), .in_data(ld_data),
    .drain(grant_ld_s), .full(ld_full_s),
    .out_sel(ld_sel_q_s), .out_rd(ld_rd_q_s), .out_data(ld_data_q_s)
  );

  assign ex_elig_s = ex_full_s & ~flush;

  // Grant selection: load first unless EX has been denied STARVE_MAX times
  always_comb begin
    grant_ex_s = 1'b0;
    grant_ld_s = 1'b0;
    if (ld_full_s && ex_elig_s) begin
      if (starve_cnt_r == STARVE_LIM) begin
        grant_ex_s = 1'b1;
      end else begin
        grant_ld_s = 1'b1;
      end
    end else if (ld_full_s) begin
      grant_ld_s = 1'b1;
    end else if (ex_elig_s) begin
      grant_ex_s = 1'b1;
    end else begin
      grant_ex_s = 1'b0;
      grant_ld_s = 1'b0;
    end
  end

  // Winner payload mux
  always_comb begin
    win_sel_s  = ex_sel_q_s;
    win_rd_s   = ex_rd_q_s;
    win_data_s = ex_data_q_s;
    if (grant_ld_s) begin
      win_sel_s  = ld_sel_q_s;
      win_rd_s   = ld_rd_q_s;
      win_data_s = ld_data_q_s;
    end else begin
      win_sel_s  = ex_sel_q_s;
      win_rd_s   = ex_rd_q_s;
      win_data_s = ex_data_q_s;
    end
  end

  // Starvation counter; a flushed slot is about to be empty, so it restarts too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (!ex_full_s || grant_ex_s || flush) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (starve_cnt_r != STARVE_LIM) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered write port; x0 grants drain silently and payload holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_rd_r    <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
      wb_sel_r   <= ALU;
    end else if ((grant_ex_s || grant_ld_s) && (win_rd_s != {REG_ADDR_W{1'b0}})) begin
      rf_we_r    <= 1'b1;
      rf_rd_r    <= win_rd_s;
      rf_wdata_r <= win_data_s;
      wb_sel_r   <= win_sel_s;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_rd    = rf_rd_r;
  assign rf_wdata = rf_wdata_r;
  assign wb_sel   = wb_sel_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of isolated single requests plus
// hand-written contention, starvation, flush and reset sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ld_valid, ld_ready, flush;
  logic [1:0]  ex_sel, wb_sel;
  logic [4:0]  ex_rd, ld_rd, rf_rd;
  logic [31:0] ex_alu_data, ex_pc_data, ld_data, rf_wdata;
  logic        rf_we;

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic        ex_v;
    logic [1:0]  ex_sel;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu;
    logic [31:0] ex_pc;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs [8];

  wb_port_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_sel(ex_sel), .ex_rd(ex_rd),
    .ex_alu_data(ex_alu_data), .ex_pc_data(ex_pc_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_sel = 2'd0; ex_rd = 5'd0; ex_alu_data = 32'h0; ex_pc_data = 32'h0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0; flush = 1'b0;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic [31:0] data);
    ex_valid = 1'b1; ex_sel = 2'd0; ex_rd = rd; ex_alu_data = data; ex_pc_data = 32'h0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
    ld_valid = 1'b1; ld_rd = rd; ld_data = data;
  endtask

  task automatic check_write(input string name, input logic [4:0] rd,
                             input logic [31:0] data, input logic [1:0] sel);
    check({name, "_we"},    64'(rf_we),    64'(1'b1));
    check({name, "_rd"},    64'(rf_rd),    64'(rd));
    check({name, "_wdata"}, 64'(rf_wdata), 64'(data));
    check({name, "_sel"},   64'(wb_sel),   64'(sel));
  endtask

  initial begin
    logic [36:0] seen [$];
    logic [36:0] exp_seq [7];
    logic        ex_fire, ld_fire, ex_sent;
    int          li;

    vecs[0] = '{1'b1, 2'd0, 5'd5,  32'h1234, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h1234,     2'd0};
    vecs[1] = '{1'b1, 2'd2, 5'd3,  32'hDEAD, 32'h400, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h400,      2'd2};
    vecs[2] = '{1'b1, 2'd1, 5'd4,  32'h55,   32'h66,  1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h55,       2'd0};
    vecs[3] = '{1'b1, 2'd3, 5'd6,  32'h77,   32'h88,  1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h77,       2'd0};
    vecs[4] = '{1'b0, 2'd0, 5'd0,  32'h0,    32'h0,   1'b1, 5'd9,  32'hCAFE,     1'b1, 5'd9,  32'hCAFE,     2'd1};
    vecs[5] = '{1'b1, 2'd0, 5'd0,  32'h99,   32'h0,   1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  32'hCAFE,     2'd1};
    vecs[6] = '{1'b0, 2'd0, 5'd0,  32'h0,    32'h0,   1'b1, 5'd0,  32'h1111,     1'b0, 5'd9,  32'hCAFE,     2'd1};
    vecs[7] = '{1'b0, 2'd0, 5'd0,  32'h0,    32'h0,   1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 2'd1};

    // Reset values
    idle();
    rst_n = 1'b0;
    #23;
    check("rst_we",       64'(rf_we),    64'(1'b0));
    check("rst_rd",       64'(rf_rd),    64'(5'd0));
    check("rst_wdata",    64'(rf_wdata), 64'(32'h0));
    check("rst_sel",      64'(wb_sel),   64'(2'd0));
    check("rst_ex_ready", 64'(ex_ready), 64'(1'b0));
    check("rst_ld_ready", 64'(ld_ready), 64'(1'b0));
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ex_ready", 64'(ex_ready), 64'(1'b1));
    check("post_rst_ld_ready", 64'(ld_ready), 64'(1'b1));
    tick();

    // Isolated single requests
    for (int i = 0; i < 8; i++) begin
      ex_valid = vecs[i].ex_v; ex_sel = vecs[i].ex_sel; ex_rd = vecs[i].ex_rd;
      ex_alu_data = vecs[i].ex_alu; ex_pc_data = vecs[i].ex_pc;
      ld_valid = vecs[i].ld_v; ld_rd = vecs[i].ld_rd; ld_data = vecs[i].ld_data;
      #1;
      check($sformatf("v%0d_ex_ready", i), 64'(ex_ready), 64'(1'b1));
      check($sformatf("v%0d_ld_ready", i), 64'(ld_ready), 64'(1'b1));
      tick();
      idle();
      tick();
      check($sformatf("v%0d_we", i),    64'(rf_we),    64'(vecs[i].exp_we));
      check($sformatf("v%0d_rd", i),    64'(rf_rd),    64'(vecs[i].exp_rd));
      check($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_sel", i),   64'(wb_sel),   64'(vecs[i].exp_sel));
      tick();
      check($sformatf("v%0d_idle_we", i),   64'(rf_we), 64'(1'b0));
      check($sformatf("v%0d_hold_rd", i),   64'(rf_rd), 64'(vecs[i].exp_rd));
    end

    // Both sources to x7 in the same cycle: load first, EX next
    drive_ld(5'd7, 32'hAA);
    drive_ex(5'd7, 32'hBB);
    tick();
    idle();
    tick();
    check_write("same_rd_first", 5'd7, 32'hAA, 2'd1);
    tick();
    check_write("same_rd_second", 5'd7, 32'hBB, 2'd0);
    tick();
    check("same_rd_done_we", 64'(rf_we), 64'(1'b0));

    // Starvation: EX pending against a stream of six loads
    exp_seq[0] = {5'd21, 32'h100};
    exp_seq[1] = {5'd21, 32'h101};
    exp_seq[2] = {5'd21, 32'h102};
    exp_seq[3] = {5'd20, 32'hE0};
    exp_seq[4] = {5'd21, 32'h103};
    exp_seq[5] = {5'd21, 32'h104};
    exp_seq[6] = {5'd21, 32'h105};
    li = 0;
    ex_sent = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (rf_we) seen.push_back({rf_rd, rf_wdata});
      idle();
      if (!ex_sent) drive_ex(5'd20, 32'hE0);
      if (li < 6) drive_ld(5'd21, 32'h100 + 32'(li));
      #1;
      ex_fire = ex_valid & ex_ready;
      ld_fire = ld_valid & ld_ready;
      tick();
      if (ex_fire) ex_sent = 1'b1;
      if (ld_fire) li++;
    end
    idle();
    check("starve_writes", 64'(seen.size()), 64'(7));
    for (int k = 0; k < 7; k++) begin
      if (k < seen.size()) check($sformatf("starve_order%0d", k), 64'(seen[k]), 64'(exp_seq[k]));
      else check($sformatf("starve_order%0d", k), 64'(37'h0), 64'(exp_seq[k]));
    end
    check("starve_cnt_clear", 64'(dut.starve_cnt_r), 64'(2'd0));

    // Flush of a pending EX entry with the load side idle
    drive_ex(5'd8, 32'h11);
    tick();
    drive_ex(5'd10, 32'h22);
    flush = 1'b1;
    #1;
    check("flush_ex_ready", 64'(ex_ready), 64'(1'b0));
    check("flush_ld_ready", 64'(ld_ready), 64'(1'b1));
    tick();
    idle();
    check("flush_we0", 64'(rf_we), 64'(1'b0));
    tick();
    check("flush_we1", 64'(rf_we), 64'(1'b0));
    drive_ex(5'd12, 32'h33);
    #1;
    check("post_flush_ready", 64'(ex_ready), 64'(1'b1));
    tick();
    idle();
    tick();
    check_write("post_flush", 5'd12, 32'h33, 2'd0);
    tick();

    // Reset while both slots hold entries
    drive_ld(5'd13, 32'h5A);
    drive_ex(5'd14, 32'hA5);
    tick();
    idle();
    tick();
    check_write("pre_rst", 5'd13, 32'h5A, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",       64'(rf_we),    64'(1'b0));
    check("mid_rst_rd",       64'(rf_rd),    64'(5'd0));
    check("mid_rst_wdata",    64'(rf_wdata), 64'(32'h0));
    check("mid_rst_sel",      64'(wb_sel),   64'(2'd0));
    check("mid_rst_ex_ready", 64'(ex_ready), 64'(1'b0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post_rst_quiet%0d", c), 64'(rf_we), 64'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
